// File: rtl/pwd_pkg.sv
// Shared constants and types for the password key transmitter: key symbol
// encodings, the idle key, the default password and the transmitter state type.
package pwd_pkg;

  localparam int KEY_W = 2;

  localparam logic [KEY_W-1:0] KEY_00 = 2'b00;
  localparam logic [KEY_W-1:0] KEY_01 = 2'b01;
  localparam logic [KEY_W-1:0] KEY_10 = 2'b10;
  localparam logic [KEY_W-1:0] KEY_11 = 2'b11;

  localparam logic [KEY_W-1:0] IDLE_KEY = KEY_00;

  // Sent first to last as 10, 01, 10, 11 (lowest symbol goes out first).
  localparam logic [7:0] PWD_DEFAULT = 8'hE6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_REPORT
  } pwd_tx_state_t;

endpackage

// File: rtl/pwd_key_shifter.sv
// Password shift register with per-key hold counter. Presents one key symbol
// per HOLD_CYCLES clocks after a load and flags the end of the last hold.
module pwd_key_shifter
  import pwd_pkg::*;
#(
  parameter int                NUM_KEYS    = 4,
  parameter int                KEY_W       = 2,
  parameter int                HOLD_CYCLES = 1,
  parameter logic [KEY_W-1:0]  IDLE_KEY    = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [NUM_KEYS*KEY_W-1:0] load_data,
  output logic [KEY_W-1:0]          key,
  output logic                      key_valid,
  output logic                      seq_end
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
  localparam int IDX_W  = $clog2(NUM_KEYS) + 1;

  logic [NUM_KEYS*KEY_W-1:0] sr_q, sr_d;
  logic [HOLD_W-1:0]         hold_q, hold_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      valid_q, valid_d;
  logic [KEY_W-1:0]          key_q, key_d;
  logic                      hold_end;

  assign hold_end = valid_q && (hold_q == HOLD_W'(HOLD_CYCLES - 1));
  assign seq_end  = hold_end && (idx_q == IDX_W'(NUM_KEYS - 1));

  always_comb begin
    sr_d    = sr_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (load) begin
      sr_d    = load_data;
      hold_d  = '0;
      idx_d   = '0;
      valid_d = 1'b1;
    end else if (seq_end) begin
      valid_d = 1'b0;
      hold_d  = '0;
      idx_d   = '0;
    end else if (hold_end) begin
      sr_d   = sr_q >> KEY_W;
      hold_d = '0;
      idx_d  = idx_q + 1'b1;
    end else if (valid_q) begin
      hold_d = hold_q + 1'b1;
    end
    // Key is computed from next-state so the output itself is a flop.
    key_d = valid_d ? sr_d[KEY_W-1:0] : IDLE_KEY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q    <= '0;
      hold_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      key_q   <= IDLE_KEY;
    end else begin
      sr_q    <= sr_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      key_q   <= key_d;
    end
  end

  assign key       = key_q;
  assign key_valid = valid_q;

endmodule

// File: rtl/pwd_key_tx.sv
// Password key transmitter: sends a latched password one key at a time, then
// waits for the lock's unlock indication and reports pass or fail.
// Optional automatic retry on timeout is enabled by defining PWD_TX_RETRY_EN.
module pwd_key_tx
  import pwd_pkg::*;
#(
  parameter int                NUM_KEYS    = 4,
  parameter int                KEY_W       = pwd_pkg::KEY_W,
  parameter int                HOLD_CYCLES = 1,
  parameter int                TIMEOUT     = 8,
  parameter logic [KEY_W-1:0]  IDLE_KEY    = pwd_pkg::IDLE_KEY
`ifdef PWD_TX_RETRY_EN
  ,
  parameter int                MAX_RETRY   = 2
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NUM_KEYS*KEY_W-1:0]     pwd,
  input  logic                          unlock_in,
  output logic [KEY_W-1:0]              key,
  output logic                          key_valid,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic                          fail
`ifdef PWD_TX_RETRY_EN
  ,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt
`endif
);

  localparam int TCNT_W = $clog2(TIMEOUT) + 1;

  pwd_tx_state_t             state_q, state_d;
  logic [TCNT_W-1:0]         tcnt_q, tcnt_d;
  logic                      pass_q, pass_d;
  logic                      fail_q, fail_d;
  logic                      load;
  logic                      seq_end;
  logic [NUM_KEYS*KEY_W-1:0] shift_data;

`ifdef PWD_TX_RETRY_EN
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  logic [RETRY_W-1:0]        retry_q, retry_d;
  logic [NUM_KEYS*KEY_W-1:0] pwd_q, pwd_d;

  // A retry resends the copy captured at start, not whatever pwd holds now.
  assign shift_data = (state_q == ST_IDLE) ? pwd : pwd_q;
  assign retry_cnt  = retry_q;
`else
  assign shift_data = pwd;
`endif

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    load    = 1'b0;
`ifdef PWD_TX_RETRY_EN
    retry_d = retry_q;
    pwd_d   = pwd_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          tcnt_d  = '0;
          state_d = ST_SEND;
`ifdef PWD_TX_RETRY_EN
          retry_d = '0;
          pwd_d   = pwd;
`endif
        end
      end
      ST_SEND: begin
        if (seq_end) begin
          tcnt_d  = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (unlock_in) begin
          pass_d  = 1'b1;
          state_d = ST_REPORT;
        end else if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
`ifdef PWD_TX_RETRY_EN
          if (retry_q < RETRY_W'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            load    = 1'b1;
            state_d = ST_SEND;
          end else begin
            fail_d  = 1'b1;
            state_d = ST_REPORT;
          end
`else
          fail_d  = 1'b1;
          state_d = ST_REPORT;
`endif
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tcnt_q  <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
`ifdef PWD_TX_RETRY_EN
      retry_q <= '0;
      pwd_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
`ifdef PWD_TX_RETRY_EN
      retry_q <= retry_d;
      pwd_q   <= pwd_d;
`endif
    end
  end

  pwd_key_shifter #(
    .NUM_KEYS   (NUM_KEYS),
    .KEY_W      (KEY_W),
    .HOLD_CYCLES(HOLD_CYCLES),
    .IDLE_KEY   (IDLE_KEY)
  ) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_data(shift_data),
    .key      (key),
    .key_valid(key_valid),
    .seq_end  (seq_end)
  );

  assign busy = (state_q == ST_SEND) || (state_q == ST_WAIT);
  assign done = (state_q == ST_REPORT);
  assign pass = pass_q;
  assign fail = fail_q;

endmodule

// File: tb/tb_pwd_key_tx.sv
// Bench for pwd_key_tx: two instances (hold 1 and hold 3) driven by a vector
// table, random transactions and hand-written reset/re-start sequences.
module tb_pwd_key_tx;

  localparam int NK       = 4;
  localparam int T        = 8;
  localparam int LOCK_LAT = 1;
  localparam logic [7:0] LOCK_PWD = 8'hE6;
`ifdef PWD_TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pwd;
  logic       start_w  [2];
  logic       unlock_w [2];
  logic [1:0] key_w    [2];
  logic       kv_w     [2];
  logic       busy_w   [2];
  logic       done_w   [2];
  logic       pass_w   [2];
  logic       fail_w   [2];
`ifdef PWD_TX_RETRY_EN
  logic [1:0] retry_w  [2];
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    pwd_key_tx #(
      .NUM_KEYS   (NK),
      .HOLD_CYCLES(gi == 0 ? 1 : 3),
      .TIMEOUT    (T)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start_w[gi]),
      .pwd      (pwd),
      .unlock_in(unlock_w[gi]),
      .key      (key_w[gi]),
      .key_valid(kv_w[gi]),
      .busy     (busy_w[gi]),
      .done     (done_w[gi]),
      .pass     (pass_w[gi]),
      .fail     (fail_w[gi])
`ifdef PWD_TX_RETRY_EN
      ,
      .retry_cnt(retry_w[gi])
`endif
    );
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: key k of a SEND phase is symbol k/hold of the password; WAIT
  // ends after the edge where unlock is sampled, or after T edges without it.
  task automatic run_txn(input int s, input logic [7:0] p, input int unl_at,
                         input bit exp_pass, input string tag);
    int h;
    int n_wait;
    bit in_window;
    h = (s == 0) ? 1 : 3;
    in_window = (unl_at >= 0) && (unl_at < T);
    pwd = p;
    start_w[s] = 1'b1;
    @(negedge clk);
    start_w[s] = 1'b0;
    for (int a = 0; a < ATTEMPTS; a++) begin
`ifdef PWD_TX_RETRY_EN
      chk({tag, " retry_cnt"}, int'(retry_w[s]), a);
`endif
      for (int k = 0; k < NK * h; k++) begin
        chk({tag, " key"},       int'(key_w[s]), int'(p[2*(k/h) +: 2]));
        chk({tag, " key_valid"}, int'(kv_w[s]),  1);
        chk({tag, " busy send"}, int'(busy_w[s]), 1);
        chk({tag, " done send"}, int'(done_w[s]), 0);
        @(negedge clk);
      end
      n_wait = in_window ? unl_at + 1 : T;
      for (int w = 0; w < n_wait; w++) begin
        unlock_w[s] = (w == unl_at);
        chk({tag, " key idle"},  int'(key_w[s]), 0);
        chk({tag, " kv wait"},   int'(kv_w[s]),  0);
        chk({tag, " busy wait"}, int'(busy_w[s]), 1);
        chk({tag, " done wait"}, int'(done_w[s]), 0);
        @(negedge clk);
      end
      unlock_w[s] = 1'b0;
      if (in_window || a == ATTEMPTS - 1) begin
        chk({tag, " done"},        int'(done_w[s]), 1);
        chk({tag, " busy report"}, int'(busy_w[s]), 0);
        chk({tag, " pass"},        int'(pass_w[s]), int'(exp_pass));
        chk({tag, " fail"},        int'(fail_w[s]), int'(!exp_pass));
        @(negedge clk);
        chk({tag, " done drop"},   int'(done_w[s]), 0);
        chk({tag, " busy idle"},   int'(busy_w[s]), 0);
        chk({tag, " pass held"},   int'(pass_w[s]), int'(exp_pass));
        $display("txn %s: sel=%0d pwd=%h unlock_at=%0d verdict=%s", tag, s, p,
                 unl_at, exp_pass ? "pass" : "fail");
        return;
      end
    end
  endtask

  typedef struct {
    int         sel;
    logic [7:0] p;
    int         unl_at;
    bit         exp_pass;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int   s;
    int   ua;
    int   dcount;
    logic [7:0] rp;

    vecs[0] = '{0, 8'hE6, LOCK_LAT, 1'b1};   // correct password, lock answers
    vecs[1] = '{0, 8'h00, -1,       1'b0};   // wrong password, full timeout
    vecs[2] = '{1, 8'hE6, LOCK_LAT, 1'b1};   // hold of 3 cycles per key
    vecs[3] = '{0, 8'h00, T - 1,    1'b1};   // unlock on final edge wins
    vecs[4] = '{1, 8'h5A, -1,       1'b0};
    vecs[5] = '{0, 8'hE6, 0,        1'b1};   // unlock on first wait edge
    vecs[6] = '{1, 8'h1B, T,        1'b0};   // unlock just too late

    rst = 1'b1;
    pwd = 8'h00;
    for (int i = 0; i < 2; i++) begin
      start_w[i]  = 1'b0;
      unlock_w[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset key",  int'(key_w[i]),  0);
      chk("reset kv",   int'(kv_w[i]),   0);
      chk("reset busy", int'(busy_w[i]), 0);
      chk("reset done", int'(done_w[i]), 0);
      chk("reset pass", int'(pass_w[i]), 0);
      chk("reset fail", int'(fail_w[i]), 0);
    end
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i].sel, vecs[i].p, vecs[i].unl_at, vecs[i].exp_pass,
              $sformatf("vec%0d", i));
    end

    // start re-pulsed while busy, then reset at key index 2
    pwd = 8'hE6;
    start_w[0] = 1'b1;
    @(negedge clk);
    start_w[0] = 1'b0;
    chk("abort key0", int'(key_w[0]), 2);
    pwd = 8'hFF;
    start_w[0] = 1'b1;
    @(negedge clk);
    start_w[0] = 1'b0;
    chk("restart ignored key1", int'(key_w[0]), 1);
    @(negedge clk);
    chk("abort key2", int'(key_w[0]), 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort key",  int'(key_w[0]),  0);
    chk("abort kv",   int'(kv_w[0]),   0);
    chk("abort busy", int'(busy_w[0]), 0);
    chk("abort pass", int'(pass_w[0]), 0);
    chk("abort fail", int'(fail_w[0]), 0);
    chk("abort pass other", int'(pass_w[1]), 0);
    dcount = 0;
    for (int c = 0; c < NK + T + 4; c++) begin
      if (done_w[0]) dcount++;
      @(negedge clk);
    end
    chk("abort no done", dcount, 0);
    $display("txn abort: reset mid-send, no verdict");
    run_txn(0, 8'hE6, LOCK_LAT, 1'b1, "after_abort");

    // Random transactions: the lock unlocks only for its password; some get a forced unlock.
    for (int i = 0; i < 10; i++) begin
      s  = int'($urandom_range(0, 1));
      rp = ($urandom_range(0, 1) == 1) ? LOCK_PWD : 8'($urandom);
      if ($urandom_range(0, 2) == 0) ua = int'($urandom_range(0, T + 2));
      else                           ua = (rp == LOCK_PWD) ? LOCK_LAT : -1;
      run_txn(s, rp, ua, (ua >= 0) && (ua < T), $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwd_key_tx.md
Name: pwd_key_tx

Overview:
- Initiator side of the password-unlock interface; drives the 2-bit `key` stream into `pwd_unlock` and judges the result from its `unlock` output.
- On `start`, latches a NUM_KEYS-entry password and emits one key per HOLD_CYCLES clocks.
- Then waits up to TIMEOUT cycles for `unlock_in` and reports pass or fail.
- Used by self-checking top levels and lock exercisers in place of hand-timed `key` stimulus.

Parameters:
- NUM_KEYS, 4, number of keys in one password sequence (min 1).
- KEY_W, 2, key symbol width.
- HOLD_CYCLES, 1, clocks each key is held on `key` (min 1).
- TIMEOUT, 8, clocks spent in WAIT looking for `unlock_in` (min 1).
- IDLE_KEY, 2'b00, value driven on `key` when not sending.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to send; sampled only in IDLE.
- pwd  in  NUM_KEYS*KEY_W  password; first key = pwd[KEY_W-1:0], key i = pwd[i*KEY_W +: KEY_W]; latched on accepted start.
- unlock_in  in  1  unlock indication from the lock.
- key  out  KEY_W  registered key symbol to the lock.
- key_valid  out  1  high while `key` carries a password symbol.
- busy  out  1  high in SEND and WAIT.
- done  out  1  one-cycle pulse when a verdict is reached.
- pass  out  1  verdict: unlock seen; held until next accepted start or rst.
- fail  out  1  verdict: timeout; held until next accepted start or rst.

Behaviour:
- Reset (rst high at posedge): state IDLE; key=IDLE_KEY; key_valid, busy, done, pass, fail all 0; counters cleared.
- Reset mid-operation has the same effect: the sequence is abandoned and no done pulse is produced.
- FSM states: IDLE, SEND, WAIT, REPORT.
- IDLE:
  - start=1 at edge N: latch pwd into the shift register, clear pass/fail, go to SEND.
  - key0 and key_valid=1 are visible from edge N to edge N+HOLD_CYCLES.
  - start is ignored in every other state (no queueing).
- SEND:
  - A hold counter counts HOLD_CYCLES; the register then shifts right by KEY_W and the next key is presented.
  - A key index counts 0..NUM_KEYS-1.
  - After the last key's hold expires, go to WAIT: key=IDLE_KEY, key_valid=0.
  - Total SEND duration is exactly NUM_KEYS*HOLD_CYCLES clocks.
  - unlock_in is not evaluated in SEND.
- WAIT:
  - The timeout counter starts at 0 and samples unlock_in each edge.
  - unlock_in=1 → go to REPORT with pass=1.
  - TIMEOUT edges elapse with unlock_in=0 → go to REPORT with fail=1.
  - If unlock_in=1 on the final timeout edge, pass wins.
- REPORT: done=1 for exactly one cycle, busy=0, then IDLE. pass/fail stay set.
- Invariants:
  - pass and fail are never both 1.
  - busy=1 exactly in SEND and WAIT.
  - key changes only on posedge.
- Counter widths: $clog2 of the respective maximum + 1. No wrap-around is reachable.

Optional Feature:
- Macro: PWD_TX_RETRY_EN.
- Defined:
  - Adds parameter MAX_RETRY (default 2) and output retry_cnt [$clog2(MAX_RETRY+1)-1:0].
  - On a WAIT timeout with retry_cnt<MAX_RETRY: increment retry_cnt, reload the latched password, return to SEND; no done pulse.
  - fail and done assert only once retries are exhausted.
  - retry_cnt clears on accepted start and on rst.
- Undefined: a single attempt; no MAX_RETRY, no retry_cnt port.

Decomposition:
- Shared package pwd_pkg holds:
  - KEY_W constant;
  - the key encoding constants KEY_00..KEY_11 and IDLE_KEY;
  - the default password constant PWD_DEFAULT = 8'hE6 (sequence 10,01,10,11);
  - the state enum typedef pwd_tx_state_t.
- One natural sub-module: pwd_key_shifter (load/shift register plus hold counter, presenting the current key). The FSM and timeout logic stay in pwd_key_tx.

Test Plan:
1. Reset, then pwd=8'hE6, start pulse at edge N, HOLD_CYCLES=1, lock = pwd_unlock → key shows 10,01,10,11 on cycles N+1..N+4 with key_valid=1; unlock seen in WAIT; done pulse, pass=1, fail=0, busy low after REPORT.
2. pwd=8'h00 against the same lock, TIMEOUT=8 → key shows 00,00,00,00; no unlock; exactly 8 WAIT cycles, then done pulse with fail=1, pass=0.
3. HOLD_CYCLES=3, pwd=8'hE6 → each key held 3 cycles (12 SEND cycles total); verdict as in scenario 1.
4. start re-pulsed while busy, and rst asserted mid-SEND at key index 2 → the start has no effect; after rst, key=00, key_valid=0, busy=0, no done pulse, pass=fail=0; the next start runs cleanly.
5. unlock_in forced high on the last WAIT edge only → pass=1 (pass wins over timeout).
6. With PWD_TX_RETRY_EN, MAX_RETRY=2, wrong pwd → three full key sequences sent; retry_cnt reaches 2; a single done pulse with fail=1 after the third timeout.
